// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request at a time.
// The fetched instruction and its PC+4 are held for the decode stage until
// it consumes them. A redirect moves the PC to a new target. A response
// already in flight for the old PC is discarded when it returns.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_add_out,
    output logic [31:0] im_out,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Sequential PC increment. It wraps naturally at 32 bits.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic        drop_r;
    logic        drop_s;
    logic        capture_s;
    logic        clear_valid_s;
    logic [31:0] redir_target_s;
    logic [31:0] pc_inc_s;
    logic [31:0] pc_add_out_r;
    logic [31:0] im_out_r;
    logic        if_valid_r;
    logic        redirect_lsb_unused_s;

    // Redirect targets are word aligned, so the low address bits are discarded.
    assign redir_target_s        = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];
    assign pc_inc_s              = pc_plus4(pc_r);

    // Next-state and next-PC decode. Redirect outranks every other transition.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        drop_s        = drop_r;
        capture_s     = 1'b0;
        clear_valid_s = 1'b0;
        case (state_r)
            FETCH: begin
                if (redirect_valid) begin
                    pc_s = redir_target_s;
                    if (imem_ready) begin
                        // The old-address request was accepted, so its response is stale.
                        state_s = WAIT;
                        drop_s  = 1'b1;
                    end else begin
                        state_s = FETCH;
                    end
                end else if (imem_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = FETCH;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_s = redir_target_s;
                    if (imem_rvalid) begin
                        state_s = FETCH;
                        drop_s  = 1'b0;
                    end else begin
                        state_s = WAIT;
                        drop_s  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_r) begin
                        state_s = FETCH;
                        drop_s  = 1'b0;
                    end else begin
                        state_s   = HOLD;
                        capture_s = 1'b1;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_s          = redir_target_s;
                    clear_valid_s = 1'b1;
                    state_s       = FETCH;
                end else if (!stall) begin
                    // The instruction is consumed on this edge.
                    pc_s          = pc_inc_s;
                    clear_valid_s = 1'b1;
                    state_s       = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s       = FETCH;
                drop_s        = 1'b0;
                clear_valid_s = 1'b1;
            end
        endcase
    end

    // State, PC and drop-flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            drop_r  <= drop_s;
        end
    end

    // Output holding registers. The data changes only when an instruction is captured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_add_out_r <= 32'h0000_0000;
            im_out_r     <= 32'h0000_0000;
            if_valid_r   <= 1'b0;
        end else if (capture_s) begin
            pc_add_out_r <= pc_inc_s;
            im_out_r     <= imem_rdata;
            if_valid_r   <= 1'b1;
        end else if (clear_valid_s) begin
            if_valid_r   <= 1'b0;
        end else begin
            if_valid_r   <= if_valid_r;
        end
    end

    // The request is a decode of the state register. It is forced low while reset is asserted.
    assign imem_req   = reset_n & (state_r == FETCH);
    assign imem_addr  = pc_r;
    assign pc_add_out = pc_add_out_r;
    assign im_out     = im_out_r;
    assign if_valid   = if_valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_if_stage;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_add_out;
    logic [31:0] im_out;
    logic        if_valid;

    int checks;
    int errors;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_add_out     (pc_add_out),
        .im_out         (im_out),
        .if_valid       (if_valid)
    );

    // 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One fetch with a zero-wait memory, starting from FETCH at pc == addr, with no stall.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] nxt;
        nxt = addr + 32'd4;
        check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", imem_addr, addr);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        check_eq("wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        check_eq("cap_valid", {31'd0, if_valid}, 32'd1);
        check_eq("cap_pc4", pc_add_out, nxt);
        check_eq("cap_im", im_out, data);
        step();
        check_eq("cons_valid", {31'd0, if_valid}, 32'd0);
        check_eq("next_addr", imem_addr, nxt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;

        // Reset state
        #2;
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_pc4", pc_add_out, 32'd0);
        check_eq("rst_im", im_out, 32'd0);
        step();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("rel_addr", imem_addr, 32'h0000_0000);

        // Back-to-back zero-wait fetches: addresses 0x0, 0x4 and 0x8
        fetch_one(32'h0000_0000, 32'h0000_0013);
        fetch_one(32'h0000_0004, 32'h0010_0093);
        fetch_one(32'h0000_0008, 32'h0020_0113);

        // Memory not ready for 3 cycles: request held at 0xC
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("nrdy_req", {31'd0, imem_req}, 32'd1);
            check_eq("nrdy_addr", imem_addr, 32'h0000_000C);
            check_eq("nrdy_valid", {31'd0, if_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0013;
        stall = 1'b1;
        step();
        imem_rvalid = 1'b0;
        check_eq("stl_valid0", {31'd0, if_valid}, 32'd1);
        // Stall for 5 cycles in HOLD: outputs stable and no request
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stl_valid", {31'd0, if_valid}, 32'd1);
            check_eq("stl_im", im_out, 32'h0000_0013);
            check_eq("stl_pc4", pc_add_out, 32'h0000_0010);
            check_eq("stl_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        check_eq("stl_next", imem_addr, 32'h0000_0010);
        check_eq("stl_nreq", {31'd0, imem_req}, 32'd1);

        // Redirect while waiting, then a stale response arrives
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check_eq("rw_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check_eq("rw_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rw_im", im_out, 32'h0000_0013);
        fetch_one(32'h0000_0100, 32'h1111_1111);

        // Redirect and response on the same edge: the response is discarded
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h2222_2222;
        step();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b0;
        check_eq("rwv_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rwv_addr", imem_addr, 32'h0000_0300);
        check_eq("rwv_im", im_out, 32'h1111_1111);

        // Redirect in FETCH with memory not ready
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();
        redirect_valid = 1'b0;
        check_eq("rf_req", {31'd0, imem_req}, 32'd1);
        check_eq("rf_addr", imem_addr, 32'h0000_0400);

        // Redirect in FETCH with the request accepted: the old response is dropped
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        imem_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h4444_4444;
        step();
        imem_rvalid = 1'b0;
        check_eq("rfa_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rfa_addr", imem_addr, 32'h0000_0500);

        // Redirect to 0x203 in HOLD while stalled
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0033;
        stall = 1'b1;
        step();
        imem_rvalid = 1'b0;
        check_eq("rh_valid1", {31'd0, if_valid}, 32'd1);
        check_eq("rh_pc4", pc_add_out, 32'h0000_0504);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        check_eq("rh_valid0", {31'd0, if_valid}, 32'd0);
        check_eq("rh_addr", imem_addr, 32'h0000_0200);
        check_eq("rh_pc4keep", pc_add_out, 32'h0000_0504);
        stall = 1'b0;

        // A stray response in FETCH is ignored
        imem_rvalid = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_rvalid = 1'b0;
        check_eq("stray_valid", {31'd0, if_valid}, 32'd0);
        check_eq("stray_im", im_out, 32'h0000_0033);

        // Reset pulse during WAIT, then a late response after release
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_req", {31'd0, imem_req}, 32'd0);
        check_eq("mrst_pc4", pc_add_out, 32'd0);
        check_eq("mrst_im", im_out, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("mrst_addr", imem_addr, 32'h0000_0000);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h6666_6666;
        step();
        imem_rvalid = 1'b0;
        check_eq("late_valid", {31'd0, if_valid}, 32'd0);
        check_eq("late_addr", imem_addr, 32'h0000_0000);
        check_eq("late_im", im_out, 32'd0);

        // PC wrap from 0xFFFFFFFC
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h7777_7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  downstream hold; output held while 1.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 SHALL have port redirect_pc  input  32  target address; bits [1:0] ignored and treated as 0.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  32  fetch address, equal to the current PC.
REQ-009 SHALL have port imem_ready  input  1  memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid  input  1  instruction data valid this cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have port pc_add_out  output  32  fetched PC + 4, registered.
REQ-013 SHALL have port im_out  output  32  fetched instruction, registered.
REQ-014 SHALL have port if_valid  output  1  pc_add_out/im_out hold a valid instruction.

Function
REQ-015 SHALL implement a state machine with three states: FETCH, WAIT and HOLD.
REQ-016 FETCH: imem_req=1 and imem_addr=pc; on imem_ready=1, the state SHALL move to WAIT; otherwise it SHALL stay in FETCH.
REQ-017 WAIT: imem_req=0; on imem_rvalid=1 with drop=0, the block SHALL set im_out<=imem_rdata, pc_add_out<=pc+4 and if_valid<=1, and move to HOLD.
REQ-018 HOLD: imem_req=0; outputs SHALL remain stable while stall=1; on stall=0, the block SHALL set if_valid<=0, pc<=pc+4 and move to FETCH.
REQ-019 The consumption point SHALL be any rising edge with if_valid=1 and stall=0; each instruction SHALL be consumed exactly once.
REQ-020 PC+4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-021 Only one memory request SHALL be outstanding; imem_rvalid outside WAIT SHALL be ignored.
REQ-022 Redirect SHALL have priority over stall and all normal transitions; on redirect_valid=1, the block SHALL set pc<={redirect_pc[31:2],2'b00}.
REQ-023 Redirect in FETCH with imem_ready=0: the state SHALL stay in FETCH, and the next cycle SHALL request the new PC.
REQ-024 Redirect in FETCH with imem_ready=1: the state SHALL move to WAIT with drop<=1, because the old-address request was accepted.
REQ-025 Redirect in WAIT with imem_rvalid=0: the block SHALL set drop<=1 and stay in WAIT.
REQ-026 Redirect in WAIT with imem_rvalid=1: the response SHALL be discarded, if_valid SHALL stay 0, and the state SHALL move to FETCH.
REQ-027 WAIT with drop=1 and imem_rvalid=1: the response SHALL be discarded, the block SHALL set drop<=0, and the state SHALL move to FETCH.
REQ-028 Redirect in HOLD: the block SHALL set if_valid<=0 regardless of stall, and the state SHALL move to FETCH.
REQ-029 Minimum latency SHALL be 2 cycles: request accepted at edge N, imem_rvalid sampled at edge N+1, if_valid=1 after edge N+1.
REQ-030 pc_add_out and im_out SHALL change only on capture (REQ-017) or reset.

Reset
REQ-031 On reset_n=0, the block SHALL immediately and asynchronously set pc=RESET_PC, state=FETCH, drop=0, if_valid=0, pc_add_out=0 and im_out=0.
REQ-032 imem_req SHALL be 0 while reset_n=0.
REQ-033 The first request after release SHALL be at the first rising edge with reset_n=1, with imem_addr=RESET_PC.
REQ-034 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid arriving after release SHALL be ignored, because the state is FETCH.

Verification
REQ-035 Zero-wait memory, stall=0 -> addresses 0x0, 0x4, 0x8 fetched; pc_add_out 0x4, 0x8, 0xC; one if_valid pulse per 3 cycles.
REQ-036 imem_ready low 3 cycles -> imem_req/imem_addr=0x0 held 4 cycles; no if_valid until imem_rvalid.
REQ-037 stall=1 for 5 cycles in HOLD, im_out=0x00000013 -> outputs stable, no new imem_req; the next request goes to 0x4 after stall falls.
REQ-038 Redirect to 0x100 in WAIT, then imem_rvalid with 0xDEADBEEF -> data discarded, if_valid stays 0, next imem_addr=0x100, pc_add_out later 0x104.
REQ-039 Redirect to 0x203 in HOLD with stall=1 -> if_valid drops next cycle, next imem_addr=0x200.
REQ-040 Reset pulse mid-WAIT, then a stray imem_rvalid after release -> ignored; imem_addr=RESET_PC; pc wrap from 0xFFFFFFFC gives pc_add_out=0x0.
